// File: rtl/switch_read_ctrl_pkg.sv
// Shared definitions for the switch read controller: FSM encoding, IO width and debounce default.
package switch_read_ctrl_pkg;

    localparam int unsigned IO_WIDTH                = 16;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 200000;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_WAIT = 2'd1,
        SRC_DONE = 2'd2
    } src_state_e;

endpackage

// File: rtl/switch_read_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debounce counter and a one-cycle
// pulse on each debounced press (release produces no pulse).
module btn_debounce
    import switch_read_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Input has disagreed for DEBOUNCE_CYCLES cycles: accept it.
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_press <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/switch_read_ctrl.sv
// Services CPU reads of the switch port: stalls until a debounced confirm press, then returns
// the switches. Optional SWITCH_PRELOAD_EN lets an idle press pre-capture the next read.
module switch_read_ctrl
    import switch_read_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = IO_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req,
    input  logic [WIDTH-1:0] switches,
    input  logic             confirm_bt,
    output logic             stall,
    output logic [WIDTH-1:0] io_rdata,
    output logic             data_valid
);

    src_state_e       r_state;
    src_state_e       w_state_d;
    logic [WIDTH-1:0] r_rdata;
    logic             w_press;
    logic             w_capture;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_confirm (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_btn   (confirm_bt),
        .o_press (w_press)
    );

`ifdef SWITCH_PRELOAD_EN
    logic r_pending;
    logic w_pending_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
        end
    end
`endif

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
`ifdef SWITCH_PRELOAD_EN
        w_pending_d = r_pending;
`endif
        case (r_state)
            SRC_IDLE: begin
`ifdef SWITCH_PRELOAD_EN
                // A preloaded (or simultaneous) press completes the read without waiting.
                if (io_req && (r_pending || w_press)) begin
                    w_state_d   = SRC_DONE;
                    w_capture   = w_press;
                    w_pending_d = 1'b0;
                end else if (io_req) begin
                    w_state_d = SRC_WAIT;
                end else if (w_press) begin
                    w_capture   = 1'b1;
                    w_pending_d = 1'b1;
                end
`else
                if (io_req) begin
                    w_state_d = SRC_WAIT;
                end
`endif
            end
            SRC_WAIT: begin
                if (!io_req) begin
                    w_state_d = SRC_IDLE;
                end else if (w_press) begin
                    w_capture = 1'b1;
                    w_state_d = SRC_DONE;
                end
            end
            SRC_DONE: w_state_d = SRC_IDLE;
            default:  w_state_d = SRC_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SRC_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_capture) begin
                r_rdata <= switches;
            end
        end
    end

    // Combinational so the PC is frozen in the very cycle the read is first presented.
    assign stall      = ~reset & io_req & ((r_state == SRC_IDLE) | (r_state == SRC_WAIT));
    assign data_valid = (r_state == SRC_DONE);
    assign io_rdata   = r_rdata;

endmodule

// File: tb/tb_switch_read_ctrl.sv
// Directed scoreboard bench for switch_read_ctrl with a short debounce window.
module tb_switch_read_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             io_req;
    logic [WIDTH-1:0] switches;
    logic             confirm_bt;
    logic             stall;
    logic [WIDTH-1:0] io_rdata;
    logic             data_valid;

    switch_read_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_req     (io_req),
        .switches   (switches),
        .confirm_bt (confirm_bt),
        .stall      (stall),
        .io_rdata   (io_rdata),
        .data_valid (data_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic             chk_stall_en = 1'b0;
    logic             exp_stall    = 1'b0;
    logic             chk_rdata_en = 1'b0;
    logic [WIDTH-1:0] exp_rdata    = '0;
    logic             final_chk    = 1'b0;

    // Monitor: sole owner of the counters; samples on the falling edge.
    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid @%0t: io_rdata=%h, no read expected", $time,
                         io_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (io_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL read_data @%0t: got %h expected %h", $time, io_rdata, mon_exp);
                end
            end
            n_tests++;
            if (stall !== 1'b0) begin
                n_fail++;
                $display("FAIL done_stall @%0t: got %b expected 0", $time, stall);
            end
        end
        if (chk_stall_en) begin
            n_tests++;
            if (stall !== exp_stall) begin
                n_fail++;
                $display("FAIL stall @%0t: got %b expected %b", $time, stall, exp_stall);
            end
        end
        if (chk_rdata_en) begin
            n_tests++;
            if (io_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL io_rdata_hold @%0t: got %h expected %h", $time, io_rdata,
                         exp_rdata);
            end
        end
        if (final_chk) begin
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_reads: %0d outstanding, expected 0", exp_q.size());
            end
        end
    end

    // Run n cycles expecting the given stall level; returns 1 time unit after a rising edge.
    task automatic step(input int n, input logic s);
        exp_stall = s;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        io_req     = 1'b1;
        confirm_bt = 1'b1;
        switches   = 16'hFFFF;
        @(posedge clock);
        #1;

        // Reset with request and button active
        chk_stall_en = 1'b1;
        chk_rdata_en = 1'b1;
        exp_rdata    = 16'h0000;
        step(3, 1'b0);
        reset      = 1'b0;
        io_req     = 1'b0;
        confirm_bt = 1'b0;
        switches   = 16'h0000;
        step(10, 1'b0);
        chk_rdata_en = 1'b0;

        // Basic read: press visible 6 cycles after the button rises, DONE one cycle later
        switches   = 16'hA5C3;
        io_req     = 1'b1;
        confirm_bt = 1'b1;
        exp_q.push_back(16'hA5C3);
        step(7, 1'b1);
        io_req = 1'b0;
        step(3, 1'b0);
        confirm_bt = 1'b0;
        step(10, 1'b0);

        // Back-to-back reads; the held button must not satisfy the second read
        switches   = 16'h0001;
        io_req     = 1'b1;
        confirm_bt = 1'b1;
        exp_q.push_back(16'h0001);
        step(7, 1'b1);
        switches = 16'h8000;
        step(1, 1'b0);
        step(2, 1'b1);
        confirm_bt = 1'b0;
        step(8, 1'b1);
        confirm_bt = 1'b1;
        exp_q.push_back(16'h8000);
        step(7, 1'b1);
        io_req = 1'b0;
        step(3, 1'b0);
        confirm_bt = 1'b0;
        step(10, 1'b0);

        // Glitch rejection: 3-cycle pulses while waiting
        io_req = 1'b1;
        step(2, 1'b1);
        confirm_bt = 1'b1;
        step(3, 1'b1);
        confirm_bt = 1'b0;
        step(3, 1'b1);
        confirm_bt = 1'b1;
        step(3, 1'b1);
        confirm_bt = 1'b0;
        step(8, 1'b1);

        // Abort from WAIT keeps the last captured value
        chk_rdata_en = 1'b1;
        exp_rdata    = 16'h8000;
        io_req       = 1'b0;
        step(4, 1'b0);

        // Reset in WAIT: stall drops in the reset cycle, data clears afterwards
        io_req = 1'b1;
        step(4, 1'b1);
        reset = 1'b1;
        step(1, 1'b0);
        reset     = 1'b0;
        io_req    = 1'b0;
        exp_rdata = 16'h0000;
        step(3, 1'b0);
        chk_rdata_en = 1'b0;

        // Press while idle, then request
        switches   = 16'h1234;
        confirm_bt = 1'b1;
        step(8, 1'b0);
        confirm_bt   = 1'b0;
        chk_rdata_en = 1'b1;
`ifdef SWITCH_PRELOAD_EN
        exp_rdata = 16'h1234;
`else
        exp_rdata = 16'h0000;
`endif
        step(10, 1'b0);
        io_req = 1'b1;
`ifdef SWITCH_PRELOAD_EN
        exp_q.push_back(16'h1234);
        step(1, 1'b1);
        io_req = 1'b0;
        step(4, 1'b0);
`else
        step(10, 1'b1);
        chk_rdata_en = 1'b0;
        switches     = 16'h4321;
        confirm_bt   = 1'b1;
        exp_q.push_back(16'h4321);
        step(7, 1'b1);
        io_req = 1'b0;
        step(3, 1'b0);
        confirm_bt = 1'b0;
        step(6, 1'b0);
`endif

        final_chk = 1'b1;
        step(1, 1'b0);
        final_chk = 1'b0;
        step(1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
